// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/bubble sequencer for the 24-bit fetch/decode/execute pipeline.
// Resolves load-use hazards, taken-branch flushes and multi-cycle memory waits.
module pipeline_hazard_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_is_load,
  input  logic [3:0]       ex_rd,
  input  logic [3:0]       dec_rs1,
  input  logic [3:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clear_counts,
  output logic             stall_f,
  output logic             stall_d,
  output logic             bubble_e,
  output logic             stall_e,
  output logic             flush_fd,
  output logic             busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       fc_q, fc_d;
  logic [7:0]       wc_q, wc_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] sc_q, fcnt_q;
  logic             hz, br_acc;
  logic             sf, sd, be, se, ff;

  assign hz = ex_is_load && (ex_rd != 4'd0) &&
              ((dec_use_rs1 && (dec_rs1 == ex_rd)) || (dec_use_rs2 && (dec_rs2 == ex_rd)));

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    wc_d    = wc_q;
    to_d    = to_q;
    br_acc  = 1'b0;
    sf = 1'b0; sd = 1'b0; be = 1'b0; se = 1'b0; ff = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          sf = 1'b1; sd = 1'b1; se = 1'b1;
          state_d = S_MEM_WAIT;
          wc_d    = 8'd1;
        end else if (branch_taken) begin
          ff = 1'b1; be = 1'b1; br_acc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            fc_d    = 3'(FLUSH_CYCLES - 1);
          end
        end else if (hz) begin
          sf = 1'b1; sd = 1'b1; be = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        // Execute is frozen here, so branch and hazard inputs are stale.
        if (mem_ready) begin
          state_d = S_RUN;
        end else begin
          sf = 1'b1; sd = 1'b1; se = 1'b1;
          wc_d = wc_q + 8'd1;
          if (wc_q == 8'(MEM_TIMEOUT)) begin
            to_d    = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_FLUSH: begin
        ff = 1'b1; be = 1'b1;
        fc_d = fc_q - 3'd1;
        if (fc_q == 3'd1) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Reset masks the controls combinationally so they drop without a clock.
  assign stall_f     = reset & sf;
  assign stall_d     = reset & sd;
  assign bubble_e    = reset & be;
  assign stall_e     = reset & se;
  assign flush_fd    = reset & ff;
  assign busy        = (state_q != S_RUN);
  assign mem_timeout = to_q;
  assign stall_count = sc_q;
  assign flush_count = fcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      fc_q    <= 3'd0;
      wc_q    <= 8'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      wc_q    <= wc_d;
      to_q    <= to_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc_q   <= '0;
      fcnt_q <= '0;
    end else if (clear_counts) begin
      sc_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (stall_f && (sc_q != '1)) sc_q <= sc_q + CNT_W'(1);
      if (br_acc && (fcnt_q != '1)) fcnt_q <= fcnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized scoreboard bench: two controller configurations share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_pipeline_hazard_controller;
  localparam int M_RUN = 0, M_WAIT = 1, M_FLUSH = 2;

  typedef struct packed {
    bit rst, ld; bit [3:0] rd, rs1, rs2; bit u1, u2, br, mrq, mrdy, clr;
  } in_t;
  typedef struct { int mode, waited, fleft, stalls, flushes; bit to; } mdl_t;
  typedef struct { bit [4:0] ctrl; bit busy, to; int sc, fc; } exp_t;
  typedef struct { exp_t a; exp_t b; } pair_t;

  logic clk = 1'b0, reset = 1'b0;
  logic ex_is_load, dec_use_rs1, dec_use_rs2, branch_taken, mem_req, mem_ready, clear_counts;
  logic [3:0] ex_rd, dec_rs1, dec_rs2;
  logic a_sf, a_sd, a_be, a_se, a_ff, a_busy, a_to;
  logic b_sf, b_sd, b_be, b_se, b_ff, b_busy, b_to;
  logic [15:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  pipeline_hazard_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .clear_counts(clear_counts), .stall_f(a_sf), .stall_d(a_sd), .bubble_e(a_be),
    .stall_e(a_se), .flush_fd(a_ff), .busy(a_busy), .mem_timeout(a_to),
    .stall_count(a_sc), .flush_count(a_fc));

  pipeline_hazard_controller #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(3), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .clear_counts(clear_counts), .stall_f(b_sf), .stall_d(b_sd), .bubble_e(b_be),
    .stall_e(b_se), .flush_fd(b_ff), .busy(b_busy), .mem_timeout(b_to),
    .stall_count(b_sc), .flush_count(b_fc));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  pair_t sb[$];
  mdl_t ma, mb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // ctrl order: {stall_f, stall_d, bubble_e, stall_e, flush_fd}
  task automatic step(input int fcyc, input int tmo, input int cmax, input mdl_t mi,
                      input in_t x, output mdl_t mo, output exp_t e);
    bit hz, acc;
    mo = mi;
    e.ctrl = 5'b0; e.busy = (mi.mode != M_RUN); e.to = mi.to;
    e.sc = mi.stalls; e.fc = mi.flushes;
    if (!x.rst) begin
      mo = '{M_RUN, 0, 0, 0, 0, 1'b0};
      e = '{5'b0, 1'b0, 1'b0, 0, 0};
      return;
    end
    hz = x.ld && x.rd != 0 && ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
    acc = 1'b0;
    if (mi.mode == M_RUN) begin
      if (x.mrq && !x.mrdy) begin
        e.ctrl = 5'b11010; mo.mode = M_WAIT; mo.waited = 1;
      end else if (x.br) begin
        e.ctrl = 5'b00101; acc = 1'b1;
        if (fcyc > 1) begin mo.mode = M_FLUSH; mo.fleft = fcyc - 1; end
      end else if (hz) e.ctrl = 5'b11100;
    end else if (mi.mode == M_WAIT) begin
      if (x.mrdy) mo.mode = M_RUN;
      else begin
        e.ctrl = 5'b11010;
        if (mi.waited == tmo) begin mo.to = 1'b1; mo.mode = M_RUN; end
        else mo.waited = mi.waited + 1;
      end
    end else begin
      e.ctrl = 5'b00101;
      mo.fleft = mi.fleft - 1;
      if (mo.fleft == 0) mo.mode = M_RUN;
    end
    if (x.clr) begin mo.stalls = 0; mo.flushes = 0; end
    else begin
      if (e.ctrl[4] && mi.stalls < cmax) mo.stalls = mi.stalls + 1;
      if (acc && mi.flushes < cmax) mo.flushes = mi.flushes + 1;
    end
  endtask

  task automatic drive(input in_t x);
    pair_t p;
    mdl_t na, nb;
    @(posedge clk); #1;
    reset = x.rst; ex_is_load = x.ld; ex_rd = x.rd; dec_rs1 = x.rs1; dec_rs2 = x.rs2;
    dec_use_rs1 = x.u1; dec_use_rs2 = x.u2; branch_taken = x.br; mem_req = x.mrq;
    mem_ready = x.mrdy; clear_counts = x.clr;
    step(2, 15, 16'hFFFF, ma, x, na, p.a);
    step(1, 3, 4'hF, mb, x, nb, p.b);
    ma = na; mb = nb;
    sb.push_back(p);
  endtask

  function automatic in_t idle();
    in_t x = '0;
    x.rst = 1'b1;
    return x;
  endfunction

  function automatic in_t hzin(input bit [3:0] r);
    in_t x = idle();
    x.ld = 1'b1; x.rd = r; x.u1 = 1'b1; x.rs1 = r;
    return x;
  endfunction

  function automatic in_t rnd(input bit longwait);
    in_t x;
    x.rst = ($urandom_range(0, 299) != 0);
    x.ld = 1'($urandom_range(0, 1));
    x.rd = 4'($urandom_range(0, 3)); x.rs1 = 4'($urandom_range(0, 3)); x.rs2 = 4'($urandom_range(0, 3));
    x.u1 = 1'($urandom_range(0, 1)); x.u2 = 1'($urandom_range(0, 1));
    x.br = ($urandom_range(0, 5) == 0);
    x.mrq = ($urandom_range(0, 3) == 0);
    x.mrdy = longwait ? ($urandom_range(0, 19) == 0) : 1'($urandom_range(0, 1));
    x.clr = ($urandom_range(0, 199) == 0);
    return x;
  endfunction

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      pair_t p;
      p = sb.pop_front();
      chk("a_ctrl", 32'({a_sf, a_sd, a_be, a_se, a_ff}), 32'(p.a.ctrl));
      chk("a_busy", 32'(a_busy), 32'(p.a.busy));
      chk("a_mem_timeout", 32'(a_to), 32'(p.a.to));
      chk("a_stall_count", 32'(a_sc), p.a.sc);
      chk("a_flush_count", 32'(a_fc), p.a.fc);
      chk("b_ctrl", 32'({b_sf, b_sd, b_be, b_se, b_ff}), 32'(p.b.ctrl));
      chk("b_busy", 32'(b_busy), 32'(p.b.busy));
      chk("b_mem_timeout", 32'(b_to), 32'(p.b.to));
      chk("b_stall_count", 32'(b_sc), p.b.sc);
      chk("b_flush_count", 32'(b_fc), p.b.fc);
    end
  end

  initial begin
    in_t x;
    ma = '{M_RUN, 0, 0, 0, 0, 1'b0};
    mb = ma;
    {ex_is_load, dec_use_rs1, dec_use_rs2, branch_taken, mem_req, mem_ready, clear_counts} = '0;
    {ex_rd, dec_rs1, dec_rs2} = '0;
    // Reset held with active hazard, branch and memory inputs: controls must stay 0.
    x = hzin(4'd3); x.rst = 1'b0; x.br = 1'b1; x.mrq = 1'b1;
    drive(x); drive(x);
    drive(idle());
    // Load-use, then register-0 non-hazard.
    drive(hzin(4'd3)); drive(idle());
    drive(hzin(4'd0)); drive(idle());
    // Branch; hazard during the second flush cycle is ignored.
    x = idle(); x.br = 1'b1; drive(x);
    drive(hzin(4'd3)); drive(idle());
    // Three-cycle memory wait, then clear.
    x = idle(); x.mrq = 1'b1;
    repeat (3) drive(x);
    x.mrdy = 1'b1; drive(x);
    x = idle(); x.clr = 1'b1; drive(x); drive(idle());
    // Timeout with ready held low; flag must stay set afterwards.
    x = idle(); x.mrq = 1'b1;
    repeat (17) drive(x);
    repeat (2) drive(idle());
    // Priority: memory stall beats branch and hazard.
    x = hzin(4'd5); x.mrq = 1'b1; x.br = 1'b1; drive(x);
    x = idle(); x.mrq = 1'b1; x.mrdy = 1'b1; drive(x);
    drive(idle());
    // Reset during a memory wait.
    x = idle(); x.mrq = 1'b1;
    repeat (2) drive(x);
    x.rst = 1'b0; drive(x); drive(x);
    drive(idle());
    // Saturate the narrow counters, hold, then clear.
    repeat (20) drive(hzin(4'd7));
    x = hzin(4'd7); x.clr = 1'b1; drive(x);
    drive(idle());
    for (int i = 0; i < 2000; i++) drive(rnd((i % 200) >= 160));
    drive(idle());
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
